// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Used by the transmit arbiter and its round-robin picker.
package uart_pkg;

    localparam int ARB_CNT_W = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: picks the first set request bit
// strictly after i_ptr, wrapping modulo NUM_REQ.
module rr_pick
    import uart_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic               o_valid
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    // Offsets 1..NUM_REQ so the previous owner is examined last.
    always_comb begin
        o_pick  = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!o_valid && i_req[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                o_valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART transmit FIFO write port between NUM_REQ byte producers,
// granting whole message bursts in round-robin order.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  byte_t [NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 fifo_full,
    output byte_t                fifo_data_o,
    output logic                 fifo_we_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output arb_state_t           o_dbg_state
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ARB_CNT_W-1:0] MAX_CNT  = ARB_CNT_W'(MAX_BURST);
    localparam logic [ARB_CNT_W-1:0] IDLE_CNT = ARB_CNT_W'(IDLE_TIMEOUT);
    localparam logic [ARB_CNT_W-1:0] CNT_ONE  = ARB_CNT_W'(1);

    arb_state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0]     r_grant, w_grant_nxt;
    logic [PTR_W-1:0]       r_gidx, w_gidx_nxt;
    logic [PTR_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [ARB_CNT_W-1:0]   r_burst_cnt, w_burst_cnt_nxt;
    logic [ARB_CNT_W-1:0]   r_idle_cnt, w_idle_cnt_nxt;

    logic [NUM_REQ-1:0]     w_pick;
    logic                   w_pick_valid;
    logic [PTR_W-1:0]       w_pick_idx;
    logic                   w_busy, w_g_valid, w_g_last, w_xfer;
    logic                   w_cap_hit, w_timeout, w_release;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_pick  (w_pick),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = PTR_W'(i);
            end
        end
    end

    assign w_busy    = (r_state == ARB_BURST);
    assign w_g_valid = req_valid[r_gidx];
    assign w_g_last  = req_last[r_gidx];
    assign w_xfer    = w_busy && w_g_valid && !fifo_full;
    // Release fires in the cycle whose count would reach the limit, so the
    // grant drops on the following edge.
    assign w_cap_hit = ((r_burst_cnt + CNT_ONE) == MAX_CNT);
    assign w_timeout = !w_g_valid && ((r_idle_cnt + CNT_ONE) == IDLE_CNT);
    assign w_release = w_busy && ((w_xfer && (w_g_last || w_cap_hit)) || w_timeout);

    assign req_ready   = (w_busy && !fifo_full) ? r_grant : '0;
    assign fifo_we_o   = w_xfer;
    assign fifo_data_o = w_xfer ? req_data[r_gidx] : '0;
    assign grant_o     = r_grant;
    assign busy_o      = w_busy;
    assign o_dbg_state = r_state;

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_gidx_nxt      = r_gidx;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;
        w_idle_cnt_nxt  = r_idle_cnt;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt     = ARB_BURST;
                    w_grant_nxt     = w_pick;
                    w_gidx_nxt      = w_pick_idx;
                    w_burst_cnt_nxt = '0;
                    w_idle_cnt_nxt  = '0;
                end
            end
            ARB_BURST: begin
                if (w_xfer) begin
                    w_burst_cnt_nxt = r_burst_cnt + CNT_ONE;
                    w_idle_cnt_nxt  = '0;
                end else if (!w_g_valid && (r_idle_cnt != '1)) begin
                    w_idle_cnt_nxt  = r_idle_cnt + CNT_ONE;
                end
                if (w_release) begin
                    w_state_nxt     = ARB_IDLE;
                    w_grant_nxt     = '0;
                    w_rr_ptr_nxt    = r_gidx;
                    w_burst_cnt_nxt = '0;
                    w_idle_cnt_nxt  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_rr_ptr    <= PTR_W'(NUM_REQ - 1);
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_gidx      <= w_gidx_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_idle_cnt  <= w_idle_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues drive the
// inputs, and every FIFO write is matched against an ordered expected queue.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int W  = 12;  // {grant[3:0], data[7:0]}

    logic                 clk;
    logic                 reset_i;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0][7:0]   req_data;
    logic [NR-1:0]        req_last;
    logic [NR-1:0]        req_ready;
    logic                 fifo_full;
    logic [7:0]           fifo_data_o;
    logic                 fifo_we_o;
    logic [NR-1:0]        grant_o;
    logic                 busy_o;
    uart_pkg::arb_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [8:0]   src_q[NR][$];  // {last, data}
    logic [NR-1:0] hs = '0;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(16), .IDLE_TIMEOUT(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_data_o (fifo_data_o),
        .fifo_we_o   (fifo_we_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_full_next(input logic v);
        @(posedge clk);
        #1 fifo_full = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_i = 1'b1;
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- driver ----------------
    task automatic push_msg(input int r, input int first, input int n, input logic last_at_end);
        for (int k = 0; k < n; k++) begin
            src_q[r].push_back({(last_at_end && (k == n - 1)), 8'(first + k)});
        end
    endtask

    task automatic push_exp(input int r, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({4'(1 << r), 8'(first + k)});
        end
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i] && (src_q[i].size() > 0)) begin
                    void'(src_q[i].pop_front());
                end
                if (src_q[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = src_q[i][0][8];
                    req_data[i]  = src_q[i][0][7:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                    req_data[i]  = '0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        hs = req_valid & req_ready;
        if (fifo_we_o === 1'b1) begin
            check_eq("sb_write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check_eq("sb_grant_data", {20'd0, grant_o, fifo_data_o}, {20'd0, exp_q.pop_front()});
            end
        end else begin
            check_eq("sb_data_zero_when_idle", {24'd0, fifo_data_o}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        reset_i   = 1'b1;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_grant", 32'(grant_o), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_we", 32'(fifo_we_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(uart_pkg::ARB_IDLE));
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);

        // T1: single requester, three bytes
        push_msg(0, 'h41, 3, 1'b1);
        push_exp(0, 'h41, 3);
        next_neg();
        check_eq("t1_no_grant_yet", 32'(grant_o), 32'd0);
        next_neg();
        check_eq("t1_grant", 32'(grant_o), 32'b0001);
        check_eq("t1_ready", 32'(req_ready), 32'b0001);
        check_eq("t1_busy", 32'(busy_o), 32'd1);
        check_eq("t1_we_b1", 32'(fifo_we_o), 32'd1);
        next_neg();
        check_eq("t1_we_b2", 32'(fifo_we_o), 32'd1);
        next_neg();
        check_eq("t1_we_b3", 32'(fifo_we_o), 32'd1);
        next_neg();
        check_eq("t1_release", 32'(grant_o), 32'd0);
        check_eq("t1_release_busy", 32'(busy_o), 32'd0);
        check_eq("t1_drain", 32'(exp_q.size()), 32'd0);

        // T2: round robin with all four requesting 1-byte messages
        do_reset();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < NR; r++) begin
                push_msg(r, 16 * (r + 1) + m, 1, 1'b1);
                push_exp(r, 16 * (r + 1) + m, 1);
            end
        end
        next_neg();
        check_eq("t2_no_grant_yet", 32'(grant_o), 32'd0);
        for (int k = 0; k < 8; k++) begin
            next_neg();
            check_eq("t2_grant", 32'(grant_o), 32'(1 << (k % 4)));
            next_neg();
            check_eq("t2_gap", 32'(grant_o), 32'd0);
        end
        check_eq("t2_drain", 32'(exp_q.size()), 32'd0);

        // T3: back-pressure on requester 1
        push_msg(1, 'h51, 4, 1'b1);
        push_exp(1, 'h51, 4);
        next_neg();
        next_neg();
        check_eq("t3_grant", 32'(grant_o), 32'b0010);
        check_eq("t3_we_b1", 32'(fifo_we_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive_full_next(1'b1);
            check_eq("t3_full_we", 32'(fifo_we_o), 32'd0);
            check_eq("t3_full_ready", 32'(req_ready), 32'd0);
            check_eq("t3_full_grant", 32'(grant_o), 32'b0010);
        end
        drive_full_next(1'b0);
        check_eq("t3_we_b2", 32'(fifo_we_o), 32'd1);
        for (int k = 0; k < 10; k++) begin
            drive_full_next(1'b1);
        end
        check_eq("t3_long_full_hold", 32'(grant_o), 32'b0010);
        drive_full_next(1'b0);
        check_eq("t3_we_b3", 32'(fifo_we_o), 32'd1);
        next_neg();
        check_eq("t3_we_b4", 32'(fifo_we_o), 32'd1);
        next_neg();
        check_eq("t3_release", 32'(grant_o), 32'd0);
        check_eq("t3_drain", 32'(exp_q.size()), 32'd0);

        // T4: burst cap on requester 2 with requester 3 pending
        push_msg(2, 'h80, 20, 1'b0);
        push_msg(3, 'hC0, 1, 1'b1);
        push_exp(2, 'h80, 16);
        push_exp(3, 'hC0, 1);
        push_exp(2, 'h90, 4);
        next_neg();
        repeat (16) next_neg();
        check_eq("t4_grant_at_16", 32'(grant_o), 32'b0100);
        next_neg();
        check_eq("t4_cap_release", 32'(grant_o), 32'd0);
        next_neg();
        check_eq("t4_req3_next", 32'(grant_o), 32'b1000);
        next_neg();
        check_eq("t4_gap", 32'(grant_o), 32'd0);
        next_neg();
        check_eq("t4_req2_resume", 32'(grant_o), 32'b0100);
        repeat (11) next_neg();
        check_eq("t4_hold_before_timeout", 32'(grant_o), 32'b0100);
        next_neg();
        check_eq("t4_timeout_release", 32'(grant_o), 32'd0);
        check_eq("t4_drain", 32'(exp_q.size()), 32'd0);

        // T5: idle timeout on requester 0, requester 1 pending
        push_msg(0, 'hE1, 1, 1'b0);
        push_msg(1, 'hF1, 1, 1'b1);
        push_exp(0, 'hE1, 1);
        push_exp(1, 'hF1, 1);
        next_neg();
        next_neg();
        check_eq("t5_grant0", 32'(grant_o), 32'b0001);
        repeat (8) next_neg();
        check_eq("t5_hold_8th_idle", 32'(grant_o), 32'b0001);
        next_neg();
        check_eq("t5_timeout_release", 32'(grant_o), 32'd0);
        next_neg();
        check_eq("t5_grant1", 32'(grant_o), 32'b0010);
        next_neg();
        check_eq("t5_drain", 32'(exp_q.size()), 32'd0);

        // T6: reset during second byte of a requester-3 burst
        push_msg(3, 'hD0, 3, 1'b1);
        push_msg(0, 'hE0, 1, 1'b1);
        exp_q.push_back({4'b1000, 8'hD0});
        exp_q.push_back({4'b1000, 8'hD1});
        exp_q.push_back({4'b0001, 8'hE0});
        exp_q.push_back({4'b1000, 8'hD2});
        next_neg();
        next_neg();
        check_eq("t6_grant3", 32'(grant_o), 32'b1000);
        @(posedge clk);
        #1 reset_i = 1'b1;
        @(negedge clk);
        check_eq("t6_second_byte", 32'(fifo_we_o), 32'd1);
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_grant", 32'(grant_o), 32'd0);
        check_eq("t6_rst_we", 32'(fifo_we_o), 32'd0);
        check_eq("t6_rst_ready", 32'(req_ready), 32'd0);
        check_eq("t6_rst_busy", 32'(busy_o), 32'd0);
        next_neg();
        check_eq("t6_restart_req0", 32'(grant_o), 32'b0001);
        next_neg();
        check_eq("t6_gap", 32'(grant_o), 32'd0);
        next_neg();
        check_eq("t6_req3_again", 32'(grant_o), 32'b1000);
        next_neg();
        check_eq("t6_drain", 32'(exp_q.size()), 32'd0);

        repeat (3) next_neg();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path (byte FIFO feeding `uart`) between NUM_REQ independent byte producers.
- Grants one requester at a time for a whole message burst, using round-robin fairness.
- Pushes the granted requester's bytes into the FIFO write port, honouring FIFO back-pressure.
- Sits between on-chip producers (debug/status sources) and `fifo.data_i` / `fifo.write_enable`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).
- IDLE_TIMEOUT, 8, consecutive cycles without req_valid from the granted requester before forced release (1..255).

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ x 8  per-requester byte.
- req_last  in  NUM_REQ  byte is last of message.
- req_ready  out  NUM_REQ  byte accepted this cycle.
- fifo_full  in  1  FIFO cannot accept a write this cycle.
- fifo_data_o  out  8  byte to FIFO data_i.
- fifo_we_o  out  1  FIFO write_enable.
- grant_o  out  NUM_REQ  one-hot current grant; all zero when idle.
- busy_o  out  1  a burst is in progress.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, grant_o=0, rr_ptr=NUM_REQ-1, burst_cnt=0, idle_cnt=0.
  - Combinationally this gives req_ready=0, fifo_we_o=0, fifo_data_o=0, busy_o=0.
- A reset mid-burst drops the grant immediately. Bytes already written stay written; no partial-burst recovery.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from rr_ptr+1 with wrap (mod NUM_REQ).
  - Next cycle: state=BURST, grant_o=one-hot(pick), burst_cnt=0, idle_cnt=0.
  - Grant latency is 1 cycle from req_valid to grant_o. No byte transfers in IDLE.
- BURST, with g = granted index:
  - req_ready[g] = !fifo_full, combinational. All other req_ready are 0.
  - fifo_we_o = req_valid[g] && !fifo_full.
  - fifo_data_o = req_data[g] when fifo_we_o, else 0.
  - Transfer = fifo_we_o. There is zero added latency from requester to FIFO.
  - On transfer: burst_cnt+=1, idle_cnt=0.
  - While req_valid[g]=0: idle_cnt+=1, saturating. fifo_full alone does not advance idle_cnt.
- BURST release happens on any of:
  - transfer with req_last[g]=1;
  - transfer that makes burst_cnt==MAX_BURST;
  - idle_cnt reaching IDLE_TIMEOUT.
- On release: next cycle state=IDLE, grant_o=0, rr_ptr=g.
- Minimum turnaround is 1 idle cycle between bursts, so a re-arbitration cycle is always visible (grant_o=0).
- Fairness: after release, g has lowest priority. With all NUM_REQ requesting, grants rotate g+1, g+2, ...
- A requester releasing by timeout or MAX_BURST keeps its position in the rotation and re-requests normally.
- Requesters must hold req_data/req_last stable while req_valid=1 and req_ready=0. The arbiter does not register them.
- Non-granted requesters' req_valid are ignored during BURST. No byte may ever be dropped or duplicated.
- Counter widths: burst_cnt and idle_cnt are 8 bits. Compare on equality, no wrap.
- busy_o = (state==BURST).

Decomposition:
- Shared package uart_pkg:
  - typedef `byte_t` (logic [7:0]);
  - enum `arb_state_t` {ARB_IDLE, ARB_BURST};
  - constant `ARB_CNT_W=8`.
- Sub-module rr_pick: combinational round-robin priority search.
  - Inputs: req vector and rr_ptr. Outputs: one-hot pick and a valid flag.
  - Separately unit-testable. The FSM and counters stay in uart_tx_arbiter.

Test Plan:
- Single requester: req0 sends 0x41,0x42,0x43 (last on 0x43), fifo_full=0 → grant_o=0001 one cycle after valid; fifo_we_o high 3 consecutive cycles with data 41,42,43; grant_o=0 on the next cycle.
- Round-robin: all 4 requesters send 1-byte messages continuously, starting after reset → grant order 0,1,2,3,0 with an idle cycle between each; each byte is written exactly once.
- Back-pressure: req1 sends 4 bytes while fifo_full is high for cycles 2-4 of the burst → fifo_we_o=0 and req_ready[1]=0 during those cycles; all 4 bytes arrive in order; idle_cnt does not advance.
- Burst cap: MAX_BURST=16, req2 streams 20 bytes with no last while req3 is pending → release after byte 16; req3 is granted next; req2 resumes afterwards with byte 17.
- Idle timeout: req0 granted, sends 1 byte then drops valid → release after exactly IDLE_TIMEOUT=8 cycles; grant moves to a pending req1.
- Reset mid-burst: assert reset_i during the 2nd byte of a burst → next cycle grant_o=0, fifo_we_o=0, req_ready=0; after deassert, arbitration restarts from req0.
